des_host_ctrl: RTL
==================

DES_HOST_CTRL -- requirements
Module: des_host_ctrl

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 2: number of clk edges after the edge that samples core_load high at which core_data_out is valid to sample (range 1..15).
REQ-002 SHALL have parameter IV_INIT, default 64'h0: CBC chaining value after reset or chain_clr.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port s_valid, input, 1: upstream block request.
REQ-006 SHALL have port s_ready, output, 1: upstream request accepted when s_valid & s_ready.
REQ-007 SHALL have port s_data, input, 64: plaintext block.
REQ-008 SHALL have port s_key, input, 64: DES key for this block.
REQ-009 SHALL have port chain_clr, input, 1: reset chaining value to IV_INIT.
REQ-010 SHALL have port core_load, output, 1: one-cycle load strobe to DES core.
REQ-011 SHALL have port core_data, output, 64: block presented to core.
REQ-012 SHALL have port core_key, output, 64: key presented to core.
REQ-013 SHALL have port core_data_out, input, 64: core result.
REQ-014 SHALL have port m_valid, output, 1: result available downstream.
REQ-015 SHALL have port m_ready, input, 1: downstream accepts when m_valid & m_ready.
REQ-016 SHALL have port m_data, output, 64: captured ciphertext.
REQ-017 SHALL have port blk_count, output, 16: completed-block counter.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD -> WAIT -> HOLD -> IDLE.
REQ-019 IDLE: s_ready=1; on s_valid, SHALL register s_data/s_key into core_data/core_key and go to LOAD.
REQ-020 LOAD: SHALL assert core_load for exactly one cycle, load wait counter with CORE_LATENCY-1, go to WAIT.
REQ-021 WAIT: SHALL decrement counter each cycle; at the edge where counter is 0, SHALL capture core_data_out into m_data and go to HOLD.
REQ-022 HOLD: m_valid=1, m_data stable; on m_ready SHALL go to IDLE and increment blk_count.
REQ-023 s_ready SHALL be 0 in LOAD, WAIT and HOLD; no new request accepted before the held result is consumed.
REQ-024 core_data and core_key SHALL stay stable from LOAD until the capture edge.
REQ-025 m_ready while m_valid=0 SHALL have no effect.
REQ-026 blk_count SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-027 Accept-to-m_valid latency SHALL be CORE_LATENCY+2 cycles (4 at default).

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, core_load=0, m_valid=0, m_data=0, core_data=0, core_key=0, blk_count=0, chaining value=IV_INIT.
REQ-029 s_ready SHALL be 0 while reset is low and 1 from the first cycle after deassertion.
REQ-030 Reset mid-operation SHALL discard the in-flight block; no m_valid for it.

Configuration
REQ-031 Macro DES_HOST_CBC_EN defined: core_data SHALL be s_data XOR chaining value at accept; each captured result SHALL replace the chaining value; chain_clr SHALL set it to IV_INIT and SHALL take priority over a simultaneous capture update.
REQ-032 Macro undefined: core_data SHALL equal s_data; chain_clr SHALL be ignored; no chaining register present.

Structure
REQ-033 Package des_host_pkg SHALL hold the state enum, DES_BLOCK_W=64, DES_KEY_W=64, BLK_CNT_W=16.
REQ-034 Chaining register and XOR SHALL reside in sub-module des_host_chain, instantiated only under DES_HOST_CBC_EN.

Verification
REQ-035 Core model returns data_in XOR 64'hFFFF_FFFF_FFFF_FFFF after 2 edges; send s_data=64'h0123456789ABCDEF, m_ready=1 -> core_load one cycle, m_valid 4 cycles after accept, m_data=64'hFEDCBA9876543210, blk_count=1.
REQ-036 m_ready held 0 for 10 cycles in HOLD -> m_valid and m_data stable, s_ready=0, second s_valid not accepted until m_ready.
REQ-037 reset low during WAIT -> all outputs at reset values, no m_valid for that block, next block completes normally.
REQ-038 Preload blk_count path with 65536 blocks -> blk_count wraps to 0.
REQ-039 DES_HOST_CBC_EN, IV_INIT=0, two blocks 64'h0 -> second core_data equals first m_data; chain_clr then block 64'h0 -> core_data=64'h0.
REQ-040 CORE_LATENCY=5 -> capture at 5th edge after core_load sampled; accept-to-m_valid = 7 cycles.

Source files
------------

// File: rtl/des_host_pkg.sv
// Shared types and widths for the DES host controller.
package des_host_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_KEY_W   = 64;
    localparam int BLK_CNT_W   = 16;
    localparam int WCNT_W      = 4;   // holds CORE_LATENCY-1 for latencies up to 15

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/des_host_chain.sv
// CBC chaining register: holds the last ciphertext and XORs it into the next plaintext.
module des_host_chain
    import des_host_pkg::*;
#(
    parameter logic [DES_BLOCK_W-1:0] IV_INIT = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chain_clr,
    input  logic                   upd,
    input  logic [DES_BLOCK_W-1:0] upd_val,
    input  logic [DES_BLOCK_W-1:0] s_data,
    output logic [DES_BLOCK_W-1:0] blk_out
);

    logic [DES_BLOCK_W-1:0] chain_q;

    // Clear has priority so a clear issued on a capture edge still restarts the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         chain_q <= IV_INIT;
        else if (chain_clr) chain_q <= IV_INIT;
        else if (upd)       chain_q <= upd_val;
    end

    assign blk_out = s_data ^ chain_q;

endmodule

// File: rtl/des_host_ctrl.sv
// Host-side sequencer for a DES core: accept a block, strobe the core, wait out
// its latency, hold the result until consumed, count completed blocks.
// Build option: define DES_HOST_CBC_EN to enable CBC chaining of plaintext.
module des_host_ctrl
    import des_host_pkg::*;
#(
    parameter int                     CORE_LATENCY = 2,
    parameter logic [DES_BLOCK_W-1:0] IV_INIT      = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DES_BLOCK_W-1:0] s_data,
    input  logic [DES_KEY_W-1:0]   s_key,
    input  logic                   chain_clr,
    output logic                   core_load,
    output logic [DES_BLOCK_W-1:0] core_data,
    output logic [DES_KEY_W-1:0]   core_key,
    input  logic [DES_BLOCK_W-1:0] core_data_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DES_BLOCK_W-1:0] m_data,
    output logic [BLK_CNT_W-1:0]   blk_count
);

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q;
    logic                   accept, capture, consume;
    logic [DES_BLOCK_W-1:0] blk_in;

`ifdef DES_HOST_CBC_EN
    des_host_chain #(.IV_INIT(IV_INIT)) u_chain (
        .clk       (clk),
        .reset     (reset),
        .chain_clr (chain_clr),
        .upd       (capture),
        .upd_val   (core_data_out),
        .s_data    (s_data),
        .blk_out   (blk_in)
    );
`else
    logic unused_chain_clr;
    assign unused_chain_clr = chain_clr;
    assign blk_in           = s_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake/strobe decode; s_ready is gated so it stays low during reset.
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        core_load = 1'b0;
        m_valid   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = reset;
                if (s_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    consume = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core operands are only written on accept, so they stay put through the wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_data <= '0;
            core_key  <= '0;
        end else if (accept) begin
            core_data <= blk_in;
            core_key  <= s_key;
        end
    end

    // Latency counter: loaded while the strobe is out, counts down to the capture edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 wcnt_q <= '0;
        else if (state_q == ST_LOAD)                wcnt_q <= WCNT_W'(CORE_LATENCY - 1);
        else if (state_q == ST_WAIT && wcnt_q != 0) wcnt_q <= wcnt_q - 1'b1;
    end

    // Result capture and completed-block count (wraps silently).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data    <= '0;
            blk_count <= '0;
        end else begin
            if (capture) m_data    <= core_data_out;
            if (consume) blk_count <= blk_count + 1'b1;
        end
    end

endmodule
